// File: rtl/serial_addsub_ctrl_pkg.sv
// addsub_pkg: shared definitions for the serial add/subtract controller.
//   state_t   : controller state encoding (2-bit binary)
//   W_DEF     : default operand/result width
//   CNT_W_DEF : default bit-counter width (2^CNT_W_DEF >= W_DEF)
package addsub_pkg;

   localparam int unsigned W_DEF     = 8;
   localparam int unsigned CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_3    = 2'd3
   } state_t;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// serial_addsub_ctrl_if: request/result bundle between the board logic and the
// serial add/sub controller.
//   btn_mode, start, a_in, b_in           : requester -> controller
//   sub_mode, busy, done, result, ovf, neg : controller -> requester/display
interface serial_addsub_ctrl_if #(
   parameter int unsigned W = 8
);
   logic         btn_mode;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         sub_mode;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         ovf;
   logic         neg;

   modport master (
      output btn_mode, start, a_in, b_in,
      input  sub_mode, busy, done, result, ovf, neg
   );

   modport slave (
      input  btn_mode, start, a_in, b_in,
      output sub_mode, busy, done, result, ovf, neg
   );
endinterface

// File: rtl/serial_addsub_ctrl_fa.sv
// serial_fa: 1-bit full adder with a registered carry.
//   clk, rst   : clock, asynchronous active-low reset
//   i_a, i_b   : operand bits for the current position
//   i_load     : load the carry with i_load_val (start of an operation)
//   i_en       : advance the carry to this bit's carry-out
//   o_sum      : sum bit for the current position
//   o_cin      : carry entering the current position
//   o_cout     : carry leaving the current position
module serial_fa (
   input  logic clk,
   input  logic rst,
   input  logic i_a,
   input  logic i_b,
   input  logic i_load,
   input  logic i_load_val,
   input  logic i_en,
   output logic o_sum,
   output logic o_cin,
   output logic o_cout
);
   logic r_carry;

   assign o_cin  = r_carry;
   assign o_sum  = i_a ^ i_b ^ r_carry;
   assign o_cout = (i_a & i_b) | (i_a & r_carry) | (i_b & r_carry);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_carry <= 1'b0;
      else if (i_load) r_carry <= i_load_val;
      else if (i_en)   r_carry <= o_cout;
   end
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: sequencer for a bit-serial add/subtract datapath.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : serial_addsub_ctrl_if slave port
//         in : btn_mode (mode toggle button level), start, a_in, b_in
//         out: sub_mode, busy (RUN), done (1-cycle strobe), result, ovf, neg
module serial_addsub_ctrl
   import addsub_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_addsub_ctrl_if.slave   bus
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

   state_t           r_state, w_next;
   logic             r_btn_q, r_sub_mode, r_op_sub;
   logic [W-1:0]     r_sha, r_shb, r_result;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             w_start, w_last, w_tog, w_run;
   logic             w_busy, w_done;
   logic             w_sum, w_cin, w_cout;

   assign w_run   = (r_state == ST_RUN);
   assign w_start = (r_state == ST_IDLE) && bus.start;
   assign w_last  = w_run && (r_cnt == LAST);
   // Toggle edges are accepted only outside RUN and are not remembered
   assign w_tog   = bus.btn_mode && !r_btn_q &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));

   serial_fa u_fa (
      .clk        (clk),
      .rst        (rst),
      .i_a        (r_sha[0]),
      .i_b        (r_shb[0] ^ r_op_sub),
      .i_load     (w_start),
      .i_load_val (r_sub_mode),
      .i_en       (w_run),
      .o_sum      (w_sum),
      .o_cin      (w_cin),
      .o_cout     (w_cout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.start) w_next = ST_RUN;
         ST_RUN:  if (r_cnt == LAST) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_RUN:  w_busy = 1'b1;
         ST_DONE: w_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_btn_q    <= 1'b0;
         r_sub_mode <= 1'b0;
      end else begin
         r_btn_q <= bus.btn_mode;
         if (w_tog) r_sub_mode <= ~r_sub_mode;
      end
   end

   // Sum bits enter shA from the top as operand bits leave the bottom, so
   // shA doubles as the accumulator and holds the full result after W shifts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sha    <= '0;
         r_shb    <= '0;
         r_op_sub <= 1'b0;
         r_cnt    <= '0;
      end else if (w_start) begin
         r_sha    <= bus.a_in;
         r_shb    <= bus.b_in;
         r_op_sub <= r_sub_mode;
         r_cnt    <= '0;
      end else if (w_run) begin
         r_sha <= {w_sum, r_sha[W-1:1]};
         r_shb <= {1'b0, r_shb[W-1:1]};
         if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Result flags are committed on the edge entering DONE so they are already
   // valid while done is high; overflow is carry-in vs carry-out of the MSB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_result <= '0;
         r_ovf    <= 1'b0;
      end else if (w_last) begin
         r_result <= {w_sum, r_sha[W-1:1]};
         r_ovf    <= w_cin ^ w_cout;
      end
   end

   assign bus.sub_mode = r_sub_mode;
   assign bus.busy     = w_busy;
   assign bus.done     = w_done;
   assign bus.result   = r_result;
   assign bus.ovf      = r_ovf;
   assign bus.neg      = r_result[W-1];
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: self-checking bench for serial_addsub_ctrl (W=8).
// Expected values come from a signed-integer reference model of A+B / A-B.
module tb_serial_addsub_ctrl;
   localparam int W = 8;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   bit         m_sub;   // model of the mode flag
   logic [7:0] m_res;   // model of the held result
   bit         m_ovf;

   serial_addsub_ctrl_if #(.W(W)) bus ();

   serial_addsub_ctrl #(.W(W), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: signed integer arithmetic, then wrap to W bits.
   function automatic void model(input logic [7:0] a, input logic [7:0] b, input bit sub,
                                 output logic [7:0] r, output bit ovf);
      int sa, sb, full;
      sa   = (a >= 128) ? int'(a) - 256 : int'(a);
      sb   = (b >= 128) ? int'(b) - 256 : int'(b);
      full = sub ? sa - sb : sa + sb;
      ovf  = (full > 127) || (full < -128);
      r    = full[7:0];
   endfunction

   // One IDLE-cycle button pulse: mode must flip on that edge.
   task automatic toggle_mode();
      bus.btn_mode = 1'b1;
      step();
      m_sub = ~m_sub;
      chk("toggle_idle", bus.sub_mode, m_sub);
      bus.btn_mode = 1'b0;
      step();
      chk("toggle_hold", bus.sub_mode, m_sub);
   endtask

   // Full operation; btn_at>=0 pulses the button at that RUN cycle,
   // tog_start raises the button together with start.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input int btn_at, input bit tog_start);
      logic [7:0] er;
      bit         eo;
      int         cyc;
      model(a, b, m_sub, er, eo);
      bus.a_in  = a;
      bus.b_in  = b;
      bus.start = 1'b1;
      if (tog_start) bus.btn_mode = 1'b1;
      step();
      bus.start    = 1'b0;
      bus.btn_mode = 1'b0;
      if (tog_start) m_sub = ~m_sub;
      chk("busy_E0", bus.busy, 1);
      chk("mode_E0", bus.sub_mode, m_sub);
      chk("hold_result", bus.result, m_res);
      bus.a_in = 8'($urandom);
      bus.b_in = 8'($urandom);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         bus.btn_mode = (cyc == btn_at);
         step();
         cyc++;
      end
      bus.btn_mode = 1'b0;
      chk("latency", cyc, W);
      chk("busy_done", bus.busy, 0);
      chk("result", bus.result, er);
      chk("ovf", bus.ovf, eo);
      chk("neg", bus.neg, er[7]);
      chk("mode_after", bus.sub_mode, m_sub);
      m_res = er;
      m_ovf = eo;
      step();
      chk("done_1cyc", bus.done, 0);
      chk("result_held", bus.result, m_res);
   endtask

   initial begin
      int dq[$];
      logic [7:0] er;
      bit eo;
      n_tests = 0;
      n_fail  = 0;
      m_sub   = 0;
      m_res   = '0;
      rst          = 1'b0;
      bus.btn_mode = 1'b0;
      bus.start    = 1'b0;
      bus.a_in     = '0;
      bus.b_in     = '0;
      step();
      step();
      chk("rst_result", bus.result, 0);
      chk("rst_mode", bus.sub_mode, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_neg", bus.neg, 0);
      rst = 1'b1;
      step();

      // Basic add, then subtract both signs
      run_op(8'd5, 8'd3, -1, 0);
      toggle_mode();
      run_op(8'd5, 8'd3, -1, 0);
      run_op(8'd3, 8'd5, -1, 0);

      // Overflow boundaries
      toggle_mode();
      run_op(8'h7F, 8'h01, -1, 0);
      toggle_mode();
      run_op(8'h80, 8'h01, -1, 0);

      // Button during RUN is dropped; button with start toggles after capture
      run_op(8'h21, 8'h13, 2, 0);
      run_op(8'h40, 8'h50, -1, 1);
      run_op(8'h40, 8'h50, -1, 0);

      // Back-to-back with start held high
      model(8'h11, 8'h22, m_sub, er, eo);
      bus.a_in  = 8'h11;
      bus.b_in  = 8'h22;
      bus.start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.done === 1'b1) begin
            dq.push_back(i);
            chk("b2b_result", bus.result, er);
         end
      end
      bus.start = 1'b0;
      m_res = er;
      chk("b2b_count", dq.size(), 3);
      for (int i = 1; i < dq.size(); i++)
         chk("b2b_spacing", dq[i] - dq[i-1], 10);
      step();

      // Abort by reset in the middle of RUN
      bus.a_in  = 8'h55;
      bus.b_in  = 8'h0F;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      rst = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_result", bus.result, 0);
      chk("abort_mode", bus.sub_mode, 0);
      chk("abort_ovf", bus.ovf, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_no_done", bus.done, 0);
      end
      rst   = 1'b1;
      m_sub = 0;
      m_res = '0;
      step();
      run_op(8'h10, 8'h20, -1, 0);

      // Randomised operands and modes
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1) toggle_mode();
         run_op(8'($urandom), 8'($urandom), -1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
